weight_addr_gen_stream: RTL and testbench

Parametrised weight-memory address generator for the CNN convolution datapath. It issues LANES consecutive weight-ROM addresses per beat and walks, for each output-map group, every output pixel's weight window. Window size, pixel count and group count are taken as runtime config latched on `start`. A valid/ready handshake lets the MAC array stall it, and a lane mask covers windows whose length is not a multiple of LANES. It sits between the layer controller and the weight BRAM read ports, one instance per conv layer.

---
 rtl/weight_addr_gen_stream_pkg.sv | 20 ++
 rtl/weight_addr_gen_stream_if.sv | 14 +
 rtl/weight_addr_gen_stream.sv | 183 ++++++++++++++++++
 tb/tb_weight_addr_gen_stream.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_addr_gen_stream_pkg.sv
// Shared types and helpers for the weight-address generator.
package weight_agen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // LSB position of a lane's address inside the packed addr bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/weight_addr_gen_stream_if.sv
// Beat bus from the address generator to the weight BRAM read ports.
interface weight_addr_gen_stream_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LANES  = 2
) ();
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES-1:0]        lane_en;
    logic                    addr_valid;
    logic                    addr_ready;
    logic                    addr_last;

    modport master (output addr, output lane_en, output addr_valid, output addr_last, input addr_ready);
    modport slave  (input addr, input lane_en, input addr_valid, input addr_last, output addr_ready);
endinterface

// File: rtl/weight_addr_gen_stream.sv
// Walks groups x pixels x window, issuing LANES consecutive weight addresses per beat.
module weight_addr_gen_stream
    import weight_agen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned LANES     = 2,
    parameter int unsigned WORDS_W   = 10,
    parameter int unsigned PIX_W     = 11,
    parameter int unsigned GRP_W     = 4,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WORDS_W-1:0] cfg_words,
    input  logic [PIX_W-1:0]   cfg_pixels,
    input  logic [GRP_W-1:0]   cfg_groups,
    weight_addr_gen_stream_if.master bus,
    output logic               busy,
    output logic               done
);

    localparam int unsigned       WC_W    = WORDS_W + 1;
    localparam logic [WC_W-1:0]   LANES_W = WC_W'(LANES);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    state_e               state_q, state_d;
    logic [WORDS_W-1:0]   words_q, words_d;
    logic [PIX_W-1:0]     pixels_q, pixels_d;
    logic [GRP_W-1:0]     groups_q, groups_d;
    logic [WC_W-1:0]      word_q, word_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load, clr;

    logic [LANES*ADDR_W-1:0] addr_q, addr_nxt;
    logic [LANES-1:0]        lane_en_q, lane_en_nxt;
    logic                    last_q, last_nxt;
    logic [WC_W-1:0]         words_ext;

    assign words_ext = {1'b0, words_q};

    // Control state, latched config, beat counters and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            words_q  <= '0;
            pixels_q <= '0;
            groups_q <= '0;
            word_q   <= '0;
            pix_q    <= '0;
            grp_q    <= '0;
            base_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            pixels_q <= pixels_d;
            groups_q <= groups_d;
            word_q   <= word_d;
            pix_q    <= pix_d;
            grp_q    <= grp_d;
            base_q   <= base_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: latch config on start, step the window/pixel/group walk on each accepted beat.
    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        pixels_d = pixels_q;
        groups_d = groups_q;
        word_d   = word_q;
        pix_d    = pix_q;
        grp_d    = grp_q;
        base_d   = base_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    words_d  = cfg_words;
                    pixels_d = cfg_pixels;
                    groups_d = cfg_groups;
                    word_d   = '0;
                    pix_d    = '0;
                    grp_d    = '0;
                    base_d   = '0;
                    busy_d   = 1'b1;
                    if (cfg_words == '0 || cfg_pixels == '0 || cfg_groups == '0)
                        state_d = DONE;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                // valid is only low in RUN on the first cycle: register beat 0 from the cleared counters.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    load    = 1'b1;
                end else if (bus.addr_ready) begin
                    if ((word_q + LANES_W) < words_ext) begin
                        word_d = word_q + LANES_W;
                        load   = 1'b1;
                    end else if (pix_q != pixels_q - PIX_W'(1)) begin
                        word_d = '0;
                        pix_d  = pix_q + PIX_W'(1);
                        load   = 1'b1;
                    end else if (grp_q != groups_q - GRP_W'(1)) begin
                        word_d = '0;
                        pix_d  = '0;
                        grp_d  = grp_q + GRP_W'(1);
                        base_d = base_q + ADDR_W'(words_q);
                        load   = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        clr     = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Empty-config passes arrive here without a pulse yet; emit it before leaving.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane address adders and lane mask for the beat being loaded.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign addr_nxt[lane_lsb(i, ADDR_W) +: ADDR_W] = BASE + base_d + ADDR_W'(word_d) + ADDR_W'(i);
        assign lane_en_nxt[i] = (word_d + WC_W'(i)) < words_ext;
    end

    assign last_nxt = ((word_d + LANES_W) >= words_ext) &&
                      (pix_d == pixels_q - PIX_W'(1)) &&
                      (grp_d == groups_q - GRP_W'(1));

    // Beat output registers: hold while stalled, clear after the final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            lane_en_q <= '0;
            last_q    <= 1'b0;
        end else if (load) begin
            addr_q    <= addr_nxt;
            lane_en_q <= lane_en_nxt;
            last_q    <= last_nxt;
        end else if (clr) begin
            addr_q    <= '0;
            lane_en_q <= '0;
            last_q    <= 1'b0;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.lane_en    = lane_en_q;
    assign bus.addr_valid = valid_q;
    assign bus.addr_last  = last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_weight_addr_gen_stream.sv
// Table-driven scoreboard bench for weight_addr_gen_stream (LANES=2 and LANES=4/wrap instances).
module tb_weight_addr_gen_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        stA, stB, busyA, busyB, doneA, doneB;
    logic [9:0]  wA, wB;
    logic [10:0] pA, pB;
    logic [3:0]  gA, gB;

    weight_addr_gen_stream_if #(.ADDR_W(12), .LANES(2)) busA ();
    weight_addr_gen_stream_if #(.ADDR_W(12), .LANES(4)) busB ();

    weight_addr_gen_stream #(.ADDR_W(12), .LANES(2), .WORDS_W(10), .PIX_W(11), .GRP_W(4), .BASE_ADDR(0)) dutA (
        .clk(clk), .reset(reset), .start(stA), .cfg_words(wA), .cfg_pixels(pA), .cfg_groups(gA),
        .bus(busA), .busy(busyA), .done(doneA));

    weight_addr_gen_stream #(.ADDR_W(12), .LANES(4), .WORDS_W(10), .PIX_W(11), .GRP_W(4), .BASE_ADDR(4090)) dutB (
        .clk(clk), .reset(reset), .start(stB), .cfg_words(wB), .cfg_pixels(pB), .cfg_groups(gB),
        .bus(busB), .busy(busyB), .done(doneB));

    typedef struct {
        logic [47:0] addr;
        logic [3:0]  en;
        logic        last;
    } beat_t;

    typedef struct {
        int sel;
        int words;
        int pixels;
        int groups;
        bit rnd;
        int exp_beats;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[7];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_cfg(input int sel, input logic st, input int w, input int p, input int g);
        if (sel == 0) begin
            stA = st; wA = 10'(w); pA = 11'(p); gA = 4'(g);
        end else begin
            stB = st; wB = 10'(w); pB = 11'(p); gB = 4'(g);
        end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 0) stA = st; else stB = st;
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) busA.addr_ready = r; else busB.addr_ready = r;
    endtask

    task automatic sample(input int sel, output logic v, output logic [47:0] a, output logic [3:0] en,
                          output logic lst, output logic bz, output logic dn);
        if (sel == 0) begin
            v = busA.addr_valid; a = {24'b0, busA.addr}; en = {2'b0, busA.lane_en};
            lst = busA.addr_last; bz = busyA; dn = doneA;
        end else begin
            v = busB.addr_valid; a = busB.addr; en = busB.lane_en;
            lst = busB.addr_last; bz = busyB; dn = doneB;
        end
    endtask

    // Reference walk: one entry per beat, addresses computed directly modulo 4096.
    task automatic push_model(input int sel, input int w, input int p, input int g);
        int L;
        int base;
        L    = (sel == 0) ? 2 : 4;
        base = (sel == 0) ? 0 : 4090;
        for (int gi = 0; gi < g; gi++)
            for (int pi = 0; pi < p; pi++)
                for (int k = 0; k < w; k += L) begin
                    beat_t b;
                    b.addr = '0;
                    b.en   = '0;
                    for (int i = 0; i < L; i++) begin
                        b.addr[i*12 +: 12] = 12'((base + gi * w + k + i) % 4096);
                        b.en[i] = (k + i < w);
                    end
                    b.last = (gi == g - 1) && (pi == p - 1) && (k + L >= w);
                    sb.push_back(b);
                end
    endtask

    // Runs one pass from a posedge+1 point and returns at a posedge+1 point.
    task automatic run_pass(input int sel, input int w, input int p, input int g, input bit rnd,
                            input int restart_at, input int reset_at, input int exp_beats);
        int          beats;
        bit          pend_done, fin, held, r;
        logic        v, lst, bz, dn, h_v, h_l;
        logic [47:0] a, h_a;
        logic [3:0]  en, h_en;
        beat_t       e;
        beats = 0; pend_done = 0; fin = 0; held = 0;
        h_v = 0; h_l = 0; h_a = '0; h_en = '0;
        sb.delete();
        push_model(sel, w, p, g);
        drive_cfg(sel, 1'b1, w, p, g);
        set_ready(sel, 1'b0);
        @(posedge clk); #1;
        drive_cfg(sel, 1'b0, $urandom_range(1, 1023), $urandom_range(1, 2047), $urandom_range(1, 15));
        sample(sel, v, a, en, lst, bz, dn);
        chk("busy_after_start", bz, 1);
        chk("valid_after_start", v, 0);
        if (w == 0 || p == 0 || g == 0) begin
            @(posedge clk); #1;
            sample(sel, v, a, en, lst, bz, dn);
            chk("empty_done", dn, 1);
            chk("empty_busy_low", bz, 0);
            chk("empty_no_valid", v, 0);
            @(posedge clk); #1;
            sample(sel, v, a, en, lst, bz, dn);
            chk("empty_done_one_cycle", dn, 0);
            chk("empty_no_valid2", v, 0);
            return;
        end
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(posedge clk); #1;
            set_start(sel, 1'b0);
            sample(sel, v, a, en, lst, bz, dn);
            if (cyc == 0) chk("first_beat_latency", v, 1);
            if (held) begin
                chk("stall_valid", v, h_v);
                chk("stall_addr", a, h_a);
                chk("stall_lane_en", en, h_en);
                chk("stall_last", lst, h_l);
            end
            if (pend_done) begin
                chk("done_after_last", dn, 1);
                chk("valid_low_at_done", v, 0);
                fin = 1;
            end else begin
                chk("no_early_done", dn, 0);
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                set_ready(sel, r);
                held = v && !r;
                h_v = v; h_a = a; h_en = en; h_l = lst;
                if (v && r) begin
                    if (sb.size() == 0) begin
                        chk("beat_beyond_model", v, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_addr", a, e.addr);
                        chk("beat_lane_en", en, e.en);
                        chk("beat_last", lst, e.last);
                        beats++;
                        if (e.last) pend_done = 1;
                    end
                    if (beats == restart_at) drive_cfg(sel, 1'b1, 7, 1, 1);
                    if (beats == reset_at) begin
                        reset = 1'b1;
                        #1;
                        sample(sel, v, a, en, lst, bz, dn);
                        chk("rst_addr", a, 0);
                        chk("rst_lane_en", en, 0);
                        chk("rst_valid", v, 0);
                        chk("rst_last", lst, 0);
                        chk("rst_busy", bz, 0);
                        chk("rst_done", dn, 0);
                        @(negedge clk);
                        reset = 1'b0;
                        set_ready(sel, 1'b0);
                        for (int k = 0; k < 5; k++) begin
                            @(posedge clk); #1;
                            sample(sel, v, a, en, lst, bz, dn);
                            chk("post_rst_quiet", {v, bz, dn}, 0);
                        end
                        sb.delete();
                        return;
                    end
                end
            end
        end
        chk("pass_finished", fin, 1);
        chk("beat_count", 64'(beats), 64'(exp_beats));
        chk("scoreboard_drained", 64'(sb.size()), 0);
        set_ready(sel, 1'b0);
        @(posedge clk); #1;
        sample(sel, v, a, en, lst, bz, dn);
        chk("done_single_pulse", dn, 0);
        chk("idle_busy_low", bz, 0);
    endtask

    initial begin
        logic        v, lst, bz, dn;
        logic [47:0] a;
        logic [3:0]  en;

        tbl[0] = '{sel: 0, words: 26, pixels: 4, groups: 1, rnd: 0, exp_beats: 52};
        tbl[1] = '{sel: 0, words: 5,  pixels: 2, groups: 3, rnd: 0, exp_beats: 18};
        tbl[2] = '{sel: 0, words: 5,  pixels: 2, groups: 3, rnd: 1, exp_beats: 18};
        tbl[3] = '{sel: 0, words: 3,  pixels: 1, groups: 1, rnd: 0, exp_beats: 2};
        tbl[4] = '{sel: 0, words: 1,  pixels: 1, groups: 1, rnd: 0, exp_beats: 1};
        tbl[5] = '{sel: 1, words: 8,  pixels: 1, groups: 1, rnd: 0, exp_beats: 2};
        tbl[6] = '{sel: 1, words: 8,  pixels: 2, groups: 2, rnd: 1, exp_beats: 8};

        drive_cfg(0, 1'b0, 0, 0, 0);
        drive_cfg(1, 1'b0, 0, 0, 0);
        busA.addr_ready = 1'b0;
        busB.addr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, v, a, en, lst, bz, dn);
            chk("reset_addr", a, 0);
            chk("reset_flags", {en, v, lst, bz, dn}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++)
            run_pass(tbl[t].sel, tbl[t].words, tbl[t].pixels, tbl[t].groups, tbl[t].rnd, -1, -1, tbl[t].exp_beats);

        run_pass(0, 26, 0, 1, 0, -1, -1, 0);
        run_pass(1, 8, 1, 0, 0, -1, -1, 0);
        run_pass(0, 5, 2, 3, 0, 3, -1, 18);
        run_pass(0, 26, 4, 1, 0, -1, 7, 0);
        run_pass(0, 5, 2, 3, 1, -1, -1, 18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
